// File: rtl/wb_arb_xbar.sv
// wb_arb_xbar: round-robin Wishbone arbiter/crossbar, one transfer per grant, address-decoded slaves.
// Optional ack timeout enabled by defining WB_ARB_XBAR_TIMEOUT_EN.
module wb_arb_xbar #(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 6,
    parameter int SEL_LSB     = 28,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NUM_M-1:0]    i_m_cyc,
    input  logic [NUM_M-1:0]    i_m_stb,
    input  logic [NUM_M-1:0]    i_m_we,
    input  logic [32*NUM_M-1:0] i_m_adr,
    input  logic [32*NUM_M-1:0] i_m_dat,
    input  logic [4*NUM_M-1:0]  i_m_sel,
    output logic [NUM_M-1:0]    o_m_ack,
    output logic [NUM_M-1:0]    o_m_err,
    output logic [32*NUM_M-1:0] o_m_dat,
    output logic [NUM_S-1:0]    o_s_cyc,
    output logic [NUM_S-1:0]    o_s_stb,
    output logic [NUM_S-1:0]    o_s_we,
    output logic [31:0]         o_s_adr,
    output logic [31:0]         o_s_dat,
    output logic [3:0]          o_s_sel,
    input  logic [NUM_S-1:0]    i_s_ack,
    input  logic [32*NUM_S-1:0] i_s_dat
);
    localparam int GW = NUM_M > 1 ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {IDLE, BUS, ERR} state_t;

    state_t          state;
    logic [GW-1:0]   grant, last_grant, nxt, cand;
    logic [3:0]      slv, nxt_slv;
    logic            found, g_cyc, g_stb, g_we, s_ack, act;
    logic [31:0]     s_dat;
    logic [NUM_M-1:0] req;
`ifdef WB_ARB_XBAR_TIMEOUT_EN
    logic [15:0]     cnt;
`endif

    assign req = i_m_cyc & i_m_stb;

    // Search starts just after the last master that completed, giving round-robin fairness
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_M);
            if (!found && req[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end
        nxt_slv = i_m_adr[int'(nxt)*32+SEL_LSB +: 4];
    end

    always_comb begin
        g_cyc = i_m_cyc[grant];
        g_stb = i_m_stb[grant];
        g_we  = i_m_we[grant];
        act   = (state == BUS) && g_cyc;
        s_ack = 1'b0;
        s_dat = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (slv == 4'(s)) begin
                s_ack = i_s_ack[s];
                s_dat = i_s_dat[s*32 +: 32];
            end
        end
        o_s_adr = (state == BUS) ? i_m_adr[int'(grant)*32 +: 32] : '0;
        o_s_dat = (state == BUS) ? i_m_dat[int'(grant)*32 +: 32] : '0;
        o_s_sel = (state == BUS) ? i_m_sel[int'(grant)*4 +: 4] : '0;
        for (int s = 0; s < NUM_S; s++) begin
            o_s_cyc[s] = act && (slv == 4'(s));
            o_s_stb[s] = act && g_stb && (slv == 4'(s));
            o_s_we[s]  = act && g_we && (slv == 4'(s));
        end
        for (int m = 0; m < NUM_M; m++) begin
            o_m_ack[m]          = act && (grant == GW'(m)) && s_ack;
            o_m_err[m]          = (state == ERR) && (grant == GW'(m));
            o_m_dat[m*32 +: 32] = (act && (grant == GW'(m))) ? s_dat : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_M - 1);
            slv        <= '0;
`ifdef WB_ARB_XBAR_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef WB_ARB_XBAR_TIMEOUT_EN
                    cnt <= '0;
`endif
                    if (found) begin
                        grant <= nxt;
                        slv   <= nxt_slv;
                        state <= ({1'b0, nxt_slv} >= 5'(NUM_S)) ? ERR : BUS;
                    end
                end
                BUS: begin
                    if (!g_cyc) begin
                        state <= IDLE;
                    end else if (s_ack) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
`ifdef WB_ARB_XBAR_TIMEOUT_EN
                    else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arb_xbar.sv
// tb_wb_arb_xbar: directed bench for wb_arb_xbar with NUM_M=2, NUM_S=6, TIMEOUT_CYC=8.
module tb_wb_arb_xbar;
  localparam int NM = 2;
  localparam int NS = 6;
  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic [NM-1:0]    i_m_cyc, i_m_stb, i_m_we;
  logic [32*NM-1:0] i_m_adr, i_m_dat;
  logic [4*NM-1:0]  i_m_sel;
  logic [NM-1:0]    o_m_ack, o_m_err;
  logic [32*NM-1:0] o_m_dat;
  logic [NS-1:0]    o_s_cyc, o_s_stb, o_s_we;
  logic [31:0]      o_s_adr, o_s_dat;
  logic [3:0]       o_s_sel;
  logic [NS-1:0]    i_s_ack;
  logic [32*NS-1:0] i_s_dat;
  logic [153:0]     all_out;
  int checks = 0;
  int failures = 0;
  always #5 i_clk = ~i_clk;
  assign all_out = {o_m_ack, o_m_err, o_m_dat, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel};
  wb_arb_xbar #(.NUM_M(NM), .NUM_S(NS), .SEL_LSB(28), .TIMEOUT_CYC(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .i_m_sel(i_m_sel),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_dat(o_m_dat),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
    .i_s_ack(i_s_ack), .i_s_dat(i_s_dat)
  );
  task automatic chk(input string tag, input logic ok, input logic [153:0] obs, input logic [153:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge i_clk);
  endtask
  task automatic req(input int m, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel);
    i_m_cyc[m]          = 1'b1;
    i_m_stb[m]          = 1'b1;
    i_m_we[m]           = we;
    i_m_adr[m*32 +: 32] = adr;
    i_m_dat[m*32 +: 32] = dat;
    i_m_sel[m*4 +: 4]   = sel;
  endtask
  task automatic drop(input int m);
    i_m_cyc[m] = 1'b0;
    i_m_stb[m] = 1'b0;
  endtask
  initial begin
    i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
    i_m_adr = '0; i_m_dat = '0; i_m_sel = '0;
    i_s_ack = '0; i_s_dat = '0;
    step();
    chk("reset_outputs", all_out === 154'h0, all_out, 154'h0);
    i_rstn = 1'b1;
    i_s_dat[31:0] = 32'h0000_BEEF;
    i_s_ack = 6'b000001;
    req(0, 32'h0, 1'b0, 32'h0, 4'h0);
    req(1, 32'h0, 1'b0, 32'h0, 4'h0);
    step();
    chk("rr_g1_m0_ack", o_m_ack === 2'b01, o_m_ack, 2'b01);
    chk("rr_g1_stb", o_s_stb === 6'b000001, o_s_stb, 6'b000001);
    step();
    chk("rr_idle1", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    chk("rr_idle1_ack", o_m_ack === 2'b00, o_m_ack, 2'b00);
    step();
    chk("rr_g2_m1_ack", o_m_ack === 2'b10, o_m_ack, 2'b10);
    chk("rr_g2_dat", o_m_dat === {32'h0000_BEEF, 32'h0}, o_m_dat, {32'h0000_BEEF, 32'h0});
    step();
    chk("rr_idle2", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    step();
    chk("rr_g3_m0_ack", o_m_ack === 2'b01, o_m_ack, 2'b01);
    drop(0);
    drop(1);
    step();
    chk("rr_end_idle", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    i_s_ack = '0;
    req(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
    step();
    chk("rd_stb", o_s_stb === 6'b000001, o_s_stb, 6'b000001);
    chk("rd_adr", o_s_adr === 32'h0000_0010, o_s_adr, 32'h0000_0010);
    chk("rd_noack", o_m_ack === 2'b00, o_m_ack, 2'b00);
    step();
    i_s_ack = 6'b000001;
    i_s_dat[31:0] = 32'h1234_5678;
    #1;
    chk("rd_ack", o_m_ack === 2'b01, o_m_ack, 2'b01);
    chk("rd_dat", o_m_dat === {32'h0, 32'h1234_5678}, o_m_dat, {32'h0, 32'h1234_5678});
    step();
    chk("rd_idle", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    drop(0);
    i_s_ack = '0;
    req(1, 32'h5000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    step();
    chk("wr_cyc", o_s_cyc === 6'b100000, o_s_cyc, 6'b100000);
    chk("wr_we", o_s_we === 6'b100000, o_s_we, 6'b100000);
    chk("wr_dat", o_s_dat === 32'hA5A5_A5A5, o_s_dat, 32'hA5A5_A5A5);
    chk("wr_sel", o_s_sel === 4'b0011, o_s_sel, 4'b0011);
    i_s_ack = 6'b000001;
    #1;
    chk("wr_stray_ack", o_m_ack === 2'b00, o_m_ack, 2'b00);
    step();
    i_s_ack = 6'b100000;
    #1;
    chk("wr_ack", o_m_ack === 2'b10, o_m_ack, 2'b10);
    step();
    chk("wr_idle", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    drop(1);
    i_s_ack = '0;
    req(0, 32'hF000_0000, 1'b0, 32'h0, 4'hF);
    step();
    chk("err_m0", o_m_err === 2'b01, o_m_err, 2'b01);
    chk("err_nostb", o_s_stb === 6'b000000, o_s_stb, 6'b000000);
    chk("err_dat", o_m_dat === 64'h0, o_m_dat, 64'h0);
    drop(0);
    step();
    chk("err_one_cycle", o_m_err === 2'b00, o_m_err, 2'b00);
    req(0, 32'h3000_0000, 1'b0, 32'h0, 4'hF);
    step();
    chk("to_stb_first", o_s_stb === 6'b001000, o_s_stb, 6'b001000);
    repeat (7) step();
    chk("to_stb_eighth", o_s_stb === 6'b001000, o_s_stb, 6'b001000);
    step();
`ifdef WB_ARB_XBAR_TIMEOUT_EN
    chk("to_err", o_m_err === 2'b01, o_m_err, 2'b01);
    chk("to_slave_dropped", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    drop(0);
    step();
    chk("to_err_cleared", o_m_err === 2'b00, o_m_err, 2'b00);
    chk("to_idle", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
`else
    chk("no_to_still_bus", o_s_stb === 6'b001000, o_s_stb, 6'b001000);
    chk("no_to_no_err", o_m_err === 2'b00, o_m_err, 2'b00);
    repeat (10) step();
    chk("no_to_long_bus", o_s_cyc === 6'b001000, o_s_cyc, 6'b001000);
    drop(0);
    #1;
    chk("drop_cyc_now", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    step();
    chk("drop_idle_cyc", o_s_cyc === 6'b000000, o_s_cyc, 6'b000000);
    chk("drop_no_ack_err", {o_m_ack, o_m_err} === 4'b0000, {o_m_ack, o_m_err}, 4'b0000);
`endif
    i_s_dat[63:32] = 32'hCAFE_0001;
    i_s_ack = 6'b000010;
    req(1, 32'h1000_0000, 1'b0, 32'h0, 4'hF);
    step();
    chk("mid_bus_ack", o_m_ack === 2'b10, o_m_ack, 2'b10);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("async_rst_outputs", all_out === 154'h0, all_out, 154'h0);
    req(0, 32'h2000_0000, 1'b0, 32'h0, 4'hF);
    i_s_ack = '0;
    step();
    chk("rst_held_outputs", all_out === 154'h0, all_out, 154'h0);
    i_rstn = 1'b1;
    step();
    chk("post_rst_m0_stb", o_s_stb === 6'b000100, o_s_stb, 6'b000100);
    chk("post_rst_m0_adr", o_s_adr === 32'h2000_0000, o_s_adr, 32'h2000_0000);
    drop(0);
    drop(1);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
